// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the UART RX deserializer and the TX side.
//   - UART_DATA_WIDTH / UART_OVERSAMPLE : default frame width and oversampling.
//   - rx_state_e                        : RX frame state machine encoding.
//   - mid_tick()                        : mid-bit tick index for an oversample.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Centre of a bit period in baud ticks; majority samples sit at MID-1..MID+1.
  function automatic int mid_tick(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer_if
// Receive-side result bus from the deserializer to the RX FIFO/register block.
//   rx_data    : received word, held until the next frame completes
//   rx_valid   : one-cycle pulse per completed frame
//   parity_err : parity mismatch, qualified by rx_valid
//   frame_err  : stop bit sampled low, qualified by rx_valid
//   rx_busy    : a frame is in progress
// Modports: master (deserializer drives), slave (consumer reads).
// -----------------------------------------------------------------------------
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  parity_err;
  logic                  frame_err;
  logic                  rx_busy;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

  modport slave (
    input rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Mid-bit capture and 2-of-3 majority vote for the UART receiver.
//   clk, rst_n  : clock, asynchronous active-low reset
//   baud_tick   : oversampling strobe
//   active      : receiver is inside a frame (sampling enabled)
//   tick_pos    : position within the bit that the current tick lands on
//   rx_in       : debounced serial line
//   bit_val     : majority of the samples at MID-1, MID, MID+1
//   bit_strobe  : high for the cycle of the MID+1 tick (decision point)
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter  int OVERSAMPLE = UART_OVERSAMPLE,
  localparam int CW         = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          baud_tick,
  input  logic          active,
  input  logic [CW-1:0] tick_pos,
  input  logic          rx_in,
  output logic          bit_val,
  output logic          bit_strobe
);

  localparam int MID = mid_tick(OVERSAMPLE);

  // The first two samples are registered; the third is the live line value on
  // the MID+1 tick, so the decision is available in the same cycle and the
  // downstream output registers add exactly one clk of latency.
  logic samp_reg [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_capture
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          samp_reg[gi] <= 1'b0;
        end else if (active && baud_tick && (tick_pos == CW'(MID - 1 + gi))) begin
          samp_reg[gi] <= rx_in;
        end
      end
    end
  endgenerate

  assign bit_strobe = active && baud_tick && (tick_pos == CW'(MID + 1));
  assign bit_val    = (samp_reg[0] & samp_reg[1]) |
                      (samp_reg[0] & rx_in)       |
                      (samp_reg[1] & rx_in);

endmodule

// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
// UART receive deserializer: start-bit validation, mid-bit majority sampling,
// optional parity check, stop-bit check, parallel word output.
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_in        : debounced serial line, idle high
//   baud_tick    : OVERSAMPLE strobes per bit period
//   parity_en    : frame carries a parity bit (latched at start of frame)
//   parity_type  : 0 = even, 1 = odd (latched at start of frame)
//   rx_if        : result bus (master) - rx_data, rx_valid, parity_err,
//                  frame_err, rx_busy
// Build option: UART_RX_PARITY_EN - when defined the PARITY state and parity
// checking exist; otherwise parity_en/parity_type are ignored and parity_err
// is always 0.
// -----------------------------------------------------------------------------
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_in,
  input  logic                    baud_tick,
  input  logic                    parity_en,
  input  logic                    parity_type,
  uart_rx_deserializer_if.master  rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_reg, state_next;
  logic [CW-1:0]         tick_cnt_reg;
  logic [CW-1:0]         tick_pos;
  logic [BW-1:0]         bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] rx_data_reg;
  logic                  rx_valid_reg;
  logic                  parity_err_reg;
  logic                  frame_err_reg;

  logic active, wrap, start_detect, last_bit;
  logic bit_val, bit_strobe;
  logic shift_en, bit_inc, par_check, deliver, busy;

  // Comparisons use the count the current tick lands on, so the first low
  // sample in IDLE is position 0 of the start bit and positions stay aligned
  // with the line for the whole frame.
  assign tick_pos     = (tick_cnt_reg == CW'(OVERSAMPLE - 1)) ? '0 : tick_cnt_reg + 1'b1;
  assign wrap         = baud_tick && (tick_cnt_reg == CW'(OVERSAMPLE - 1));
  assign active       = (state_reg != IDLE);
  assign start_detect = (state_reg == IDLE) && baud_tick && !rx_in;
  assign last_bit     = (bit_cnt_reg == BW'(DATA_WIDTH - 1));

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .active     (active),
    .tick_pos   (tick_pos),
    .rx_in      (rx_in),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe)
  );

`ifdef UART_RX_PARITY_EN
  logic par_en_reg, par_type_reg, parity_bad_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_reg     <= 1'b0;
      par_type_reg   <= 1'b0;
      parity_bad_reg <= 1'b0;
    end else if (start_detect) begin
      // Configuration is frozen per frame; a frame without parity reports 0.
      par_en_reg     <= parity_en;
      par_type_reg   <= parity_type;
      parity_bad_reg <= 1'b0;
    end else if (par_check) begin
      parity_bad_reg <= (^shift_reg) ^ bit_val ^ par_type_reg;
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_type;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_detect) state_next = START;
      end
      START: begin
        if (bit_strobe && bit_val) state_next = IDLE;  // false start
        else if (wrap)             state_next = DATA;
      end
      DATA: begin
        if (wrap && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_next = par_en_reg ? PARITY : STOP;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (wrap) state_next = STOP;
      end
`endif
      STOP: begin
        // Leave at the decision rather than the wrap so a start bit that
        // follows immediately is caught on the next tick.
        if (bit_strobe) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    shift_en  = 1'b0;
    bit_inc   = 1'b0;
    par_check = 1'b0;
    deliver   = 1'b0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      DATA: begin
        shift_en = bit_strobe;
        bit_inc  = wrap && !last_bit;
      end
      PARITY: par_check = bit_strobe;
      STOP:   deliver   = bit_strobe;
      default: ;
    endcase
  end

  // Counters, shift register and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      if (start_detect) begin
        tick_cnt_reg <= '0;
      end else if (active && baud_tick) begin
        tick_cnt_reg <= tick_pos;
      end

      if (start_detect) begin
        bit_cnt_reg <= '0;
      end else if (bit_inc) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end

      // LSB arrives first, so shift in from the top.
      if (shift_en) begin
        shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
      end

      rx_valid_reg <= deliver;
      if (deliver) begin
        rx_data_reg   <= shift_reg;
        frame_err_reg <= !bit_val;
`ifdef UART_RX_PARITY_EN
        parity_err_reg <= parity_bad_reg;
`else
        parity_err_reg <= 1'b0;
`endif
      end
    end
  end

  assign rx_if.rx_data    = rx_data_reg;
  assign rx_if.rx_valid   = rx_valid_reg;
  assign rx_if.parity_err = parity_err_reg;
  assign rx_if.frame_err  = frame_err_reg;
  assign rx_if.rx_busy    = busy;

endmodule
